// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory responder.
// IMEM_WAIT_EN adds the WAIT state used for programmable wait states.
package imem_pkg;
   localparam int IMEM_DEPTH = 64;
   localparam int WORD_W     = 32;
   localparam int WAIT_W     = 3;
   localparam int LD_AW      = 6;

`ifdef IMEM_WAIT_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RESP = 2'd2
   } state_t;
`endif
endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port, one registered read port, no reset.
// A read and a write to the same word on the same edge returns the old word.
module imem_array
   import imem_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [LD_AW-1:0]  waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [LD_AW-1:0]  raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i && (int'(waddr_i) < DEPTH)) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: valid/ready request/response handshake over imem_array.
// IMEM_WAIT_EN adds wait_cfg and a down-counting WAIT state before RESP.
module imem_responder
   import imem_pkg::WORD_W, imem_pkg::WAIT_W, imem_pkg::LD_AW;
   import imem_pkg::state_t, imem_pkg::ST_IDLE, imem_pkg::ST_RESP;
`ifdef IMEM_WAIT_EN
   import imem_pkg::ST_WAIT;
`endif
#(
   parameter int IMEM_DEPTH = imem_pkg::IMEM_DEPTH,
   parameter int ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              res,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_data,
   output logic              rsp_err,
   input  logic              rsp_ready,
   input  logic              ld_en,
   input  logic [LD_AW-1:0]  ld_addr,
`ifdef IMEM_WAIT_EN
   input  logic [WAIT_W-1:0] wait_cfg,
`endif
   input  logic [WORD_W-1:0] ld_data
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;
   logic              accept;
   logic [WORD_W-1:0] rdata;
`ifdef IMEM_WAIT_EN
   logic [WAIT_W-1:0] wait_q, wait_d;
`endif

   function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
      return (a[1:0] != 2'b00) || (int'(a[ADDR_W-1:2]) >= IMEM_DEPTH);
   endfunction

   assign req_ready = !res && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
   assign accept    = req_valid && req_ready;

`ifdef IMEM_WAIT_EN
   assign rd_addr = (state_q == ST_WAIT) ? addr_q : req_addr;
`else
   assign rd_addr = req_addr;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rd_en   = 1'b0;
`ifdef IMEM_WAIT_EN
      wait_d  = wait_q;
`endif
      case (state_q)
         ST_IDLE, ST_RESP: begin
            if ((state_q == ST_RESP) && rsp_ready) state_d = ST_IDLE;
            if (accept) begin
               addr_d = req_addr;
`ifdef IMEM_WAIT_EN
               if (wait_cfg != '0) begin
                  state_d = ST_WAIT;
                  wait_d  = wait_cfg;
               end else begin
                  state_d = ST_RESP;
                  rd_en   = 1'b1;
               end
`else
               state_d = ST_RESP;
               rd_en   = 1'b1;
`endif
            end
         end
`ifdef IMEM_WAIT_EN
         ST_WAIT: begin
            // terminal count of 1 so RESP lands exactly wait_cfg cycles after WAIT entry
            if (wait_q == WAIT_W'(1)) begin
               state_d = ST_RESP;
               rd_en   = 1'b1;
               wait_d  = '0;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
`ifdef IMEM_WAIT_EN
         wait_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
`ifdef IMEM_WAIT_EN
         wait_q  <= wait_d;
`endif
      end
   end

   imem_array #(
      .DEPTH (IMEM_DEPTH)
   ) u_array (
      .clk_i   (clk),
      .we_i    (ld_en),
      .waddr_i (ld_addr),
      .wdata_i (ld_data),
      .re_i    (rd_en),
      .raddr_i (LD_AW'(rd_addr[ADDR_W-1:2])),
      .rdata_o (rdata)
   );

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_err   = rsp_valid && addr_bad(addr_q);
   assign rsp_data  = (rsp_valid && !addr_bad(addr_q)) ? rdata : '0;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: handshake, errors, stall, reset abort,
// read-before-write, and wait states when IMEM_WAIT_EN is defined.
module tb_imem_responder;

   logic        clk = 1'b0;
   logic        res;
   logic        req_valid;
   logic [7:0]  req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        rsp_ready;
   logic        ld_en;
   logic [5:0]  ld_addr;
   logic [31:0] ld_data;
   logic [2:0]  wait_cfg;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   imem_responder dut (
      .clk       (clk),
      .res       (res),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rsp_ready (rsp_ready),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
`ifdef IMEM_WAIT_EN
      .wait_cfg  (wait_cfg),
`endif
      .ld_data   (ld_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [5:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      step();
      ld_en = 1'b0;
   endtask

   initial begin
      res = 1'b1; req_valid = 1'b0; req_addr = 8'h00; rsp_ready = 1'b0;
      ld_en = 1'b0; ld_addr = 6'd0; ld_data = 32'h0; wait_cfg = 3'd0;
      step(); step();
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
      chk("rst_rsp_data",  rsp_data,           32'h0);

      res = 1'b0;
      #1;
      chk("rel_req_ready", {31'b0, req_ready}, 32'd1);

      load(6'd0, 32'h11223344);
      load(6'd1, 32'hAABBCCDD);
      load(6'd2, 32'h55667788);

      // back-to-back fetches of 0x00 and 0x04
      rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 8'h00;
      #1;
      chk("b2b_ready0", {31'b0, req_ready}, 32'd1);
      step();
      req_addr = 8'h04;
      #1;
      chk("b2b_valid0", {31'b0, rsp_valid}, 32'd1);
      chk("b2b_data0",  rsp_data,           32'h11223344);
      chk("b2b_err0",   {31'b0, rsp_err},   32'd0);
      chk("b2b_ready1", {31'b0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      #1;
      chk("b2b_valid1", {31'b0, rsp_valid}, 32'd1);
      chk("b2b_data1",  rsp_data,           32'hAABBCCDD);
      step();
      chk("b2b_idle_valid", {31'b0, rsp_valid}, 32'd0);
      chk("b2b_idle_data",  rsp_data,           32'h0);
      chk("b2b_idle_ready", {31'b0, req_ready}, 32'd1);

      // misaligned address
      req_valid = 1'b1; req_addr = 8'h06;
      step();
      req_valid = 1'b0;
      chk("mis_valid", {31'b0, rsp_valid}, 32'd1);
      chk("mis_err",   {31'b0, rsp_err},   32'd1);
      chk("mis_data",  rsp_data,           32'h0);
      step();
      chk("mis_idle_err", {31'b0, rsp_err}, 32'd0);

      // stall in RESP; a different pending address must not disturb the response
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'h04;
      step();
      req_addr = 8'h08;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
         chk("stall_data",  rsp_data,           32'hAABBCCDD);
         chk("stall_ready", {31'b0, req_ready}, 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("stall_release_ready", {31'b0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      chk("stall_next_data", rsp_data, 32'h55667788);
      step();

      // reset right after an accept aborts the transaction
      req_valid = 1'b1; req_addr = 8'h00;
      step();
      req_valid = 1'b0; res = 1'b1;
      #1;
      chk("abort_valid_in_rst", {31'b0, rsp_valid}, 32'd0);
      step(); step();
      res = 1'b0;
      #1;
      chk("abort_ready_rel", {31'b0, req_ready}, 32'd1);
      step();
      chk("abort_valid_after", {31'b0, rsp_valid}, 32'd0);
      chk("abort_ready_after", {31'b0, req_ready}, 32'd1);

      // write to word 2 on the edge its fetch enters RESP
      req_valid = 1'b1; req_addr = 8'h08;
      ld_en = 1'b1; ld_addr = 6'd2; ld_data = 32'hDEAD0000;
      step();
      req_valid = 1'b0; ld_en = 1'b0;
      chk("rbw_old", rsp_data, 32'h55667788);
      step();
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("rbw_new", rsp_data, 32'hDEAD0000);
      step();

`ifdef IMEM_WAIT_EN
      wait_cfg = 3'd3; req_valid = 1'b1; req_addr = 8'h00;
      step();
      req_valid = 1'b0; wait_cfg = 3'd0;
      for (int i = 0; i < 3; i++) begin
         chk("wait_valid", {31'b0, rsp_valid}, 32'd0);
         chk("wait_ready", {31'b0, req_ready}, 32'd0);
         step();
      end
      chk("wait_resp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("wait_resp_data",  rsp_data,           32'h11223344);
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
